// File: rtl/stack_ram_responder.sv
// stack_ram_responder: memory-side responder for the start/done RAM transfer protocol.
// Serves one read or write request at a time. Each request moves up to MAX_WORDS 16-bit
// words between the wide transfer bus and a synchronous single-port word RAM, then
// raises the matching done flag until the initiator drops its start.
//
// Ports:
//   clock, reset_n        clock and asynchronous active-low reset
//   read_start            read request level, held until read_done is seen
//   write_start           write request level, held until write_done is seen
//   address               start word address
//   bytes                 transfer length in bits; words = min(ceil(bytes/16), MAX_WORDS)
//   write_data            write payload, word k at [BusW-1-16k -: 16]
//   read_data             read payload, same packing
//   read_done, write_done completion flags
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  RAM port (read data 1 cycle latency)
module stack_ram_responder #(
  parameter int unsigned MAX_WORDS = 16,
  parameter int unsigned MEM_AW    = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    read_start,
  input  logic                    write_start,
  input  logic [15:0]             address,
  input  logic [15:0]             bytes,
  input  logic [MAX_WORDS*16-1:0] write_data,
  output logic [MAX_WORDS*16-1:0] read_data,
  output logic                    read_done,
  output logic                    write_done,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [MEM_AW-1:0]       mem_addr,
  output logic [15:0]             mem_wdata,
  input  logic [15:0]             mem_rdata
);

  localparam int unsigned BusW = MAX_WORDS * 16;
  localparam int unsigned CntW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    StIdle, StWrite, StRead, StReadLast, StDoneW, StDoneR
  } state_e;

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [CntW-1:0]   len_q, len_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BusW-1:0]   wdata_q, wdata_d;
  logic [BusW-1:0]   rdata_q, rdata_d;
  logic              read_done_q, read_done_d;
  logic              write_done_q, write_done_d;

  logic [16:0]       req_words;  // ceil(bytes/16) before clamping
  logic [CntW-1:0]   req_len;
  logic              capture;
  logic [CntW-1:0]   cap_idx;

  assign req_words = ({1'b0, bytes} + 17'd15) >> 4;
  assign req_len   = (req_words > 17'(MAX_WORDS)) ? CntW'(MAX_WORDS) : req_words[CntW-1:0];

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    read_done_d  = 1'b0;
    write_done_d = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    capture      = 1'b0;
    // RAM data arriving now belongs to the word issued on the previous cycle.
    cap_idx      = cnt_q - CntW'(1);

    unique case (state_q)
      StIdle: begin
        if (write_start) begin
          addr_d  = MEM_AW'(address);
          len_d   = req_len;
          cnt_d   = '0;
          wdata_d = write_data;
          state_d = (req_len == '0) ? StDoneW : StWrite;
        end else if (read_start) begin
          addr_d  = MEM_AW'(address);
          len_d   = req_len;
          cnt_d   = '0;
          rdata_d = '0;
          state_d = (req_len == '0) ? StDoneR : StRead;
        end
      end
      StWrite: begin
        // Gate the RAM access with start so an aborted write commits nothing further.
        if (!write_start) begin
          state_d = StIdle;
        end else begin
          mem_en  = 1'b1;
          mem_we  = 1'b1;
          addr_d  = addr_q + MEM_AW'(1);
          cnt_d   = cnt_q + CntW'(1);
          wdata_d = wdata_q << 16;
          if (cnt_d == len_q) state_d = StDoneW;
        end
      end
      StRead: begin
        if (!read_start) begin
          state_d = StIdle;
        end else begin
          mem_en  = 1'b1;
          capture = (cnt_q != '0);
          addr_d  = addr_q + MEM_AW'(1);
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_d == len_q) state_d = StReadLast;
        end
      end
      StReadLast: begin
        if (!read_start) begin
          state_d = StIdle;
        end else begin
          capture = 1'b1;
          state_d = StDoneR;
        end
      end
      StDoneW: begin
        if (write_start) write_done_d = 1'b1;
        else             state_d      = StIdle;
      end
      StDoneR: begin
        if (read_start) read_done_d = 1'b1;
        else            state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (capture) begin
      for (int i = 0; i < MAX_WORDS; i++) begin
        if (cap_idx == CntW'(i)) rdata_d[BusW-1-16*i -: 16] = mem_rdata;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      read_done_q  <= 1'b0;
      write_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      read_done_q  <= read_done_d;
      write_done_q <= write_done_d;
    end
  end

  assign read_data  = rdata_q;
  assign read_done  = read_done_q;
  assign write_done = write_done_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q[BusW-1 -: 16];

endmodule

// File: doc/stack_ram_responder.md
Name: stack_ram_responder

Overview:
- Responder (memory) end of the start/done RAM transfer protocol the processor core uses as initiator for instruction fetch and stack access.
- Accepts one read or one write request at a time and moves up to sixteen 16-bit words between the 256-bit transfer bus and an external synchronous single-port word RAM.
- Raises the matching done flag when the transfer is complete.
- One instance per initiator port; the stack path and the fetch path each get their own instance.

Parameters:
- MAX_WORDS, 16, maximum words per transfer; equals bus width / 16.
- MEM_AW, 16, memory word-address width; addresses wrap modulo 2^MEM_AW.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous active-low reset.
- read_start  input  1  initiator read request level; held high until read_done is seen.
- write_start  input  1  initiator write request level; held high until write_done is seen.
- address  input  16  start address, in 16-bit-word units.
- bytes  input  16  transfer length in bits (field name is historical); words = ceil(bytes/16).
- write_data  input  256  write payload; word k is bits [255-16k -: 16].
- read_data  output  256  read payload, same packing as write_data.
- read_done  output  1  read complete.
- write_done  output  1  write complete.
- mem_en  output  1  RAM access enable.
- mem_we  output  1  RAM write enable; qualified by mem_en.
- mem_addr  output  MEM_AW  RAM word address.
- mem_wdata  output  16  RAM write word.
- mem_rdata  input  16  RAM read word; valid exactly 1 cycle after an mem_en && !mem_we cycle.

Behaviour:
- Reset: all outputs 0, read_data 0, state IDLE. Asynchronous, effective mid-transfer; the RAM contents of the interrupted write are undefined beyond words already committed.
- Length:
  - N = min(ceil(bytes/16), MAX_WORDS).
  - bytes=0 gives N=0: no RAM access, done asserts on the edge after the sampling edge.
  - bytes above 256 are clamped to 16 words (bytes=255 gives 16 words).
- Latching: address, N and write_data are latched on the edge that leaves IDLE. Later changes while busy are ignored.
- States: IDLE, WRITE, READ, READ_LAST, DONE_W, DONE_R.
- IDLE:
  - write_start=1 goes to WRITE. Write has priority when both starts are high.
  - Otherwise read_start=1 goes to READ and clears read_data to 0.
- WRITE:
  - Each cycle drives mem_en=1, mem_we=1, mem_addr=address+k, mem_wdata=word k, for k=0..N-1.
  - After word N-1, go to DONE_W.
  - write_done rises N+1 edges after the sampling edge.
- READ:
  - Each cycle drives mem_en=1, mem_we=0, mem_addr=address+k.
  - mem_rdata is captured into word k one cycle later.
  - After issuing word N-1, go to READ_LAST, which captures the final word and then goes to DONE_R.
  - read_done rises N+2 edges after the sampling edge.
  - Unrequested words remain 0.
- DONE_W / DONE_R:
  - The done flag is held high and read_data is held stable while the corresponding start is high.
  - When start is seen low: done clears on that edge and the state returns to IDLE.
  - A new request can be sampled on the following edge.
- Abort: if the active start drops before DONE, go to IDLE on that edge with done kept 0. Words already written stay written; read_data is partial.
- Wrap: mem_addr = (address + k) mod 2^MEM_AW.
- Pending read during a write: the read is serviced only after the write handshake closes and read_start is still high.
- mem_en=0 in IDLE and in the DONE states; mem_wdata is don't-care when mem_we=0.

Test Plan:
- Single-word write, then single-word read:
  - write_start, address=0x0010, bytes=16, write_data[255:240]=0xBEEF -> one mem write at 0x0010 with data 0xBEEF; write_done on edge 2.
  - read_start, same address -> read_data[255:240]=0xBEEF, rest 0; read_done on edge 3.
- 64-bit fetch: preload 0x0100..0x0103 = 1,2,3,4; read, bytes=64 -> read_data[255:192]=0x0001_0002_0003_0004, lower bits 0; read_done on edge 6.
- Full transfer, bytes=255:
  - Write 16 words 0xA000+k at address 0xFFF8 -> mem_addr sequence 0xFFF8..0xFFFF, 0x0000..0x0007.
  - Read back -> identical 256 bits; read_done on edge 18.
- Simultaneous read_start and write_start in IDLE -> write runs first; read starts only after write_start drops; no RAM access overlaps.
- Abort: drop read_start after 3 issued words of an N=8 read -> IDLE next edge, read_done never rises.
- Reset and zero length:
  - Assert reset_n=0 mid-write -> all outputs 0 immediately.
  - After release, write with bytes=0 -> write_done on edge 1 with mem_en never high.
